dog_window_buffer: RTL

Parametrised K×K sliding-window buffer feeding the DoG/extrema stage. It accepts one K-pixel image column per beat from the line buffers and keeps a registered K×K window in image orientation for both serpentine scan directions. It emits the window with its centre coordinates under a valid/ready handshake. It is the generalised successor of the fixed 5×5 window stage, adding back-pressure, direction-aware shifting, fill tracking and optional left-border replication.

---
 rtl/dog_win_pkg.sv | 33 +++
 rtl/dog_win_fill_ctrl.sv | 80 ++++++++
 rtl/dog_window_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dog_win_pkg.sv
// Shared defaults, types and helpers for the DoG K x K sliding-window buffer.
// Build option: DOGWIN_REPLICATE_EN enables left-border replication on line restart.
package dog_win_pkg;

  localparam int unsigned K_DEF  = 5;
  localparam int unsigned PW_DEF = 8;
  localparam int unsigned CW_DEF = 8;

  localparam logic DIR_L2R = 1'b0;
  localparam logic DIR_R2L = 1'b1;

`ifdef DOGWIN_REPLICATE_EN
  localparam bit REPLICATE_EN = 1'b1;
`else
  localparam bit REPLICATE_EN = 1'b0;
`endif

  typedef logic [PW_DEF-1:0] pix_t;
  typedef logic [CW_DEF-1:0] coord_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } fill_state_e;

  // Centre column of a window whose newest column sits at x; callers truncate to CW.
  function automatic logic [31:0] centre_x(input logic [31:0] x,
                                           input logic        dir,
                                           input int unsigned h);
    return (dir == DIR_L2R) ? (x - h) : (x + h);
  endfunction

endpackage

// File: rtl/dog_win_fill_ctrl.sv
// Fill/stream control for the window buffer: column count, stored direction,
// restart detection and the valid/ready handshake. Honours DOGWIN_REPLICATE_EN.
module dog_win_fill_ctrl
  import dog_win_pkg::*;
#(
  parameter int unsigned K = K_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in_valid,
  input  logic i_in_sol,
  input  logic i_in_dir,
  input  logic i_out_ready,
  output logic o_in_ready_c,
  output logic o_accept_c,
  output logic o_restart_c,
  output logic o_load_c,
  output logic o_out_valid
);

  localparam int unsigned H    = (K - 1) / 2;
  localparam int unsigned CNTW = $clog2(K + 1);

  localparam logic [CNTW-1:0] FULL_CNT    = CNTW'(K);
  localparam logic [CNTW-1:0] RESTART_CNT = REPLICATE_EN ? CNTW'(H + 1) : CNTW'(1);

  fill_state_e     r_state;
  logic [CNTW-1:0] r_cnt;
  logic            r_dir;
  logic            r_out_valid;

  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_restart;
  logic            w_load;

  // A zero count only exists straight after reset, so it forces a restart.
  assign w_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_restart  = w_accept && (i_in_sol || (i_in_dir != r_dir) || (r_cnt == '0));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_restart) begin
      w_cnt_nxt = RESTART_CNT;
    end else if (w_accept && (r_state == FILL)) begin
      w_cnt_nxt = r_cnt + CNTW'(1);
    end
  end

  assign w_load = w_accept && (w_cnt_nxt == FULL_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_dir       <= DIR_L2R;
      r_out_valid <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= (w_cnt_nxt == FULL_CNT) ? STREAM : FILL;
      if (w_restart) begin
        r_dir <= i_in_dir;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready_c = w_in_ready;
  assign o_accept_c   = w_accept;
  assign o_restart_c  = w_restart;
  assign o_load_c     = w_load;
  assign o_out_valid  = r_out_valid;

endmodule

// File: rtl/dog_window_buffer.sv
// K x K sliding window in image orientation for serpentine scans, with a
// registered valid/ready output. Build option: DOGWIN_REPLICATE_EN.
module dog_window_buffer
  import dog_win_pkg::*;
#(
  parameter int unsigned K  = K_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*PW-1:0]   in_col,
  input  logic [CW-1:0]     in_x,
  input  logic [CW-1:0]     in_y,
  input  logic              in_dir,
  input  logic              in_sol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K*K*PW-1:0] out_win,
  output logic [CW-1:0]     out_x,
  output logic [CW-1:0]     out_y,
  output logic              out_dir
);

  localparam int unsigned H = (K - 1) / 2;

  if ((K < 3) || (K > 9) || ((K % 2) == 0)) begin : g_bad_k
    $error("dog_window_buffer: K must be odd and within 3..9");
  end

  logic [PW-1:0]     r_win     [K][K];
  logic [PW-1:0]     w_win_nxt [K][K];
  logic [K*K*PW-1:0] r_out_win;
  logic [CW-1:0]     r_out_x;
  logic [CW-1:0]     r_out_y;
  logic              r_out_dir;

  logic w_in_ready;
  logic w_accept;
  logic w_restart;
  logic w_load;
  logic w_out_valid;

  dog_win_fill_ctrl #(
    .K (K)
  ) u_fill_ctrl (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (in_valid),
    .i_in_sol     (in_sol),
    .i_in_dir     (in_dir),
    .i_out_ready  (out_ready),
    .o_in_ready_c (w_in_ready),
    .o_accept_c   (w_accept),
    .o_restart_c  (w_restart),
    .o_load_c     (w_load),
    .o_out_valid  (w_out_valid)
  );

  // Next window: shift away from the entry side, or replicate on restart.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_win_nxt[r][c] = r_win[r][c];
      end
    end
    if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        if (REPLICATE_EN && w_restart) begin
          for (int c = 0; c < K; c++) begin
            w_win_nxt[r][c] = in_col[r*PW +: PW];
          end
        end else if (in_dir == DIR_L2R) begin
          for (int c = 0; c < K - 1; c++) begin
            w_win_nxt[r][c] = r_win[r][c+1];
          end
          w_win_nxt[r][K-1] = in_col[r*PW +: PW];
        end else begin
          for (int c = 1; c < K; c++) begin
            w_win_nxt[r][c] = r_win[r][c-1];
          end
          w_win_nxt[r][0] = in_col[r*PW +: PW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= w_win_nxt[r][c];
        end
      end
    end
  end

  // Output register only changes when a full window is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_win <= '0;
      r_out_x   <= '0;
      r_out_y   <= '0;
      r_out_dir <= DIR_L2R;
    end else if (w_load) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_out_win[(r*K+c)*PW +: PW] <= w_win_nxt[r][c];
        end
      end
      r_out_x   <= CW'(centre_x(32'(in_x), in_dir, H));
      r_out_y   <= in_y;
      r_out_dir <= in_dir;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_win   = r_out_win;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_dir   = r_out_dir;

endmodule
